// File: rtl/tag_tx_pkg.sv
// Shared definitions for the tag reply path: the FSM encoding, the FM0 preamble
// pattern and the CRC-16/CCITT constants.
package tag_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PILOT,
        ST_PREAMBLE,
        ST_DATA,
        ST_CRC,
        ST_DUMMY,
        ST_DONE
    } tx_state_t;

    // Half-symbol levels of the preamble, first half-symbol in the MSB.
    // The pattern includes the FM0 violation.
    localparam logic [11:0] PREAMBLE_HALVES   = 12'b1101_0010_0011;
    localparam logic [15:0] CRC_POLY          = 16'h1021;
    localparam logic [15:0] CRC_PRESET        = 16'hFFFF;
    localparam int          PILOT_LEN_DEFAULT = 12;

    localparam logic [4:0]  PREAMBLE_LAST_BIT = 5'd5;
    localparam logic [4:0]  CRC_LAST_BIT      = 5'd15;

    // Level of one preamble half-symbol, addressed as (bit index, half).
    function automatic logic preamble_level(input logic [2:0] bit_idx, input logic half);
        logic [3:0] idx;
        idx = {bit_idx, half};
        return PREAMBLE_HALVES[4'd11 - idx];
    endfunction

endpackage

// File: rtl/crc16_ccitt_ser.sv
// Bit-serial CRC-16/CCITT. The register is preset by init and advances one
// payload bit for each cycle in which en is high.
module crc16_ccitt_ser
    import tag_tx_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        init,
    input  logic        en,
    input  logic        bit_in,
    output logic [15:0] crc
);

    logic [15:0] r_crc;
    logic        w_feedback;

    assign w_feedback = r_crc[15] ^ bit_in;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_crc <= CRC_PRESET;
        end else if (init) begin
            r_crc <= CRC_PRESET;
        end else if (en) begin
            r_crc <= {r_crc[14:0], 1'b0} ^ (w_feedback ? CRC_POLY : 16'h0000);
        end
    end

    assign crc = r_crc;

endmodule

// File: rtl/tx_fm0_encoder.sv
// FM0 reply-frame encoder. It sends an optional pilot tone, the preamble, the
// payload fetched bit by bit, an optional CRC-16 and a dummy data-1 bit.
module tx_fm0_encoder
    import tag_tx_pkg::*;
#(
    parameter int PILOT_LEN = PILOT_LEN_DEFAULT
) (
    input  logic data_clk,
    input  logic reset,
    input  logic tx_start,
    input  logic trext,
    input  logic crc_en,
    input  logic tx_bit_in,
    input  logic tx_last,
    output logic bit_req,
    output logic tx_out,
    output logic tx_busy,
    output logic tx_done
);

    localparam logic [4:0] PILOT_LAST_BIT = 5'(PILOT_LEN - 1);

    tx_state_t   r_state;
    logic [4:0]  r_cnt;
    logic        r_half;
    logic        r_tx_out;
    logic        r_data_bit;
    logic        r_last;
    logic        r_crc_en;

    tx_state_t   w_nxt_state;
    logic [4:0]  w_nxt_cnt;
    logic        w_nxt_half;
    logic        w_nxt_tx_out;
    logic        w_start;
    logic        w_sample;
    logic        w_cur_bit;
    logic        w_h2_level;
    logic [15:0] w_crc;

    crc16_ccitt_ser u_crc (
        .clk    (data_clk),
        .reset  (reset),
        .init   (w_start),
        .en     (w_sample),
        .bit_in (tx_bit_in),
        .crc    (w_crc)
    );

    // Value of the bit currently on air; CRC bits go out ones-complemented, MSB first.
    always_comb begin
        w_cur_bit = 1'b1;
        case (r_state)
            ST_PILOT: w_cur_bit = 1'b0;
            ST_DATA:  w_cur_bit = r_data_bit;
            ST_CRC:   w_cur_bit = ~w_crc[4'd15 - r_cnt[3:0]];
            default:  w_cur_bit = 1'b1;
        endcase
    end

    // A data-0 flips in mid-symbol, a data-1 holds its level.
    assign w_h2_level = r_tx_out ^ ~w_cur_bit;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
        w_nxt_state  = r_state;
        w_nxt_cnt    = r_cnt;
        w_nxt_half   = r_half;
        w_nxt_tx_out = r_tx_out;
        w_start      = 1'b0;
        w_sample     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_nxt_tx_out = 1'b0;
                if (tx_start) begin
                    w_start    = 1'b1;
                    w_nxt_cnt  = 5'd0;
                    w_nxt_half = 1'b0;
                    if (trext) begin
                        w_nxt_state  = ST_PILOT;
                        w_nxt_tx_out = 1'b1;
                    end else begin
                        w_nxt_state  = ST_PREAMBLE;
                        w_nxt_tx_out = preamble_level(3'd0, 1'b0);
                    end
                end
            end
            ST_PILOT: begin
                w_nxt_half = ~r_half;
                if (!r_half) begin
                    w_nxt_tx_out = w_h2_level;
                end else if (r_cnt == PILOT_LAST_BIT) begin
                    w_nxt_state  = ST_PREAMBLE;
                    w_nxt_cnt    = 5'd0;
                    w_nxt_tx_out = preamble_level(3'd0, 1'b0);
                end else begin
                    w_nxt_cnt    = r_cnt + 5'd1;
                    w_nxt_tx_out = ~r_tx_out;
                end
            end
            ST_PREAMBLE: begin
                w_nxt_half = ~r_half;
                if (!r_half) begin
                    w_nxt_tx_out = preamble_level(r_cnt[2:0], 1'b1);
                end else if (r_cnt == PREAMBLE_LAST_BIT) begin
                    w_nxt_state  = ST_DATA;
                    w_nxt_cnt    = 5'd0;
                    w_nxt_tx_out = ~r_tx_out;
                    w_sample     = 1'b1;
                end else begin
                    w_nxt_cnt    = r_cnt + 5'd1;
                    w_nxt_tx_out = preamble_level(r_cnt[2:0] + 3'd1, 1'b0);
                end
            end
            ST_DATA: begin
                w_nxt_half = ~r_half;
                if (!r_half) begin
                    w_nxt_tx_out = w_h2_level;
                end else begin
                    w_nxt_tx_out = ~r_tx_out;
                    if (r_last) begin
                        w_nxt_state = r_crc_en ? ST_CRC : ST_DUMMY;
                        w_nxt_cnt   = 5'd0;
                    end else begin
                        w_sample = 1'b1;
                    end
                end
            end
            ST_CRC: begin
                w_nxt_half = ~r_half;
                if (!r_half) begin
                    w_nxt_tx_out = w_h2_level;
                end else begin
                    w_nxt_tx_out = ~r_tx_out;
                    if (r_cnt == CRC_LAST_BIT) begin
                        w_nxt_state = ST_DUMMY;
                        w_nxt_cnt   = 5'd0;
                    end else begin
                        w_nxt_cnt = r_cnt + 5'd1;
                    end
                end
            end
            ST_DUMMY: begin
                w_nxt_half = ~r_half;
                if (!r_half) begin
                    w_nxt_tx_out = w_h2_level;
                end else begin
                    w_nxt_state  = ST_DONE;
                    w_nxt_tx_out = 1'b0;
                end
            end
            ST_DONE: begin
                w_nxt_state  = ST_IDLE;
                w_nxt_tx_out = 1'b0;
            end
            default: begin
                w_nxt_state  = ST_IDLE;
                w_nxt_cnt    = 5'd0;
                w_nxt_half   = 1'b0;
                w_nxt_tx_out = 1'b0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop updates from pre-edge values.
    always_ff @(posedge data_clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 5'd0;
            r_half     <= 1'b0;
            r_tx_out   <= 1'b0;
            r_data_bit <= 1'b0;
            r_last     <= 1'b0;
            r_crc_en   <= 1'b0;
        end else begin
            r_state  <= w_nxt_state;
            r_cnt    <= w_nxt_cnt;
            r_half   <= w_nxt_half;
            r_tx_out <= w_nxt_tx_out;
            if (w_start) begin
                r_crc_en <= crc_en;
                r_last   <= 1'b0;
            end
            if (w_sample) begin
                r_data_bit <= tx_bit_in;
                r_last     <= tx_last;
            end
        end
    end

    assign tx_out  = r_tx_out;
    assign tx_busy = (r_state != ST_IDLE);
    assign tx_done = (r_state == ST_DONE);
    assign bit_req = ((r_state == ST_PREAMBLE) && (r_cnt == PREAMBLE_LAST_BIT) && r_half) ||
                     ((r_state == ST_DATA) && r_half && !r_last);

endmodule
